// File: rtl/ser_bus_pkg.sv
// Shared definitions for the scl/sda frame link. The downstream receiver
// imports this package as well, so the bus levels and phase numbers stay in step.
package ser_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int   PH_START = 0;
    localparam logic SCL_IDLE = 1'b1;
    localparam logic SDA_IDLE = 1'b1;

    // Last phase of a frame: start, two phases per data bit, then three for the stop.
    function automatic int PH_STOP(input int data_w);
        return 2 * data_w + 3;
    endfunction

endpackage

// File: rtl/ser_frame_tx_scl_tick_gen.sv
// Half-period tick generator for the serial clock. Emits one tick every HALF
// cycles while run is high, and sits at zero while run is low.
module scl_tick_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = run && (r_cnt == CW'(HALF - 1));

endmodule

// File: rtl/ser_frame_tx.sv
// Parallel-to-serial frame transmitter: accepts a word on a valid/ready
// handshake and sends it on scl/sda as start, MSB-first data, stop.
module ser_frame_tx
    import ser_bus_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              scl,
    output logic              sda,
    output logic              busy,
    output logic              done
);

    localparam int PH_LAST = PH_STOP(DATA_W);
    localparam int PW      = $clog2(2 * DATA_W + 4);

    state_t            r_state;
    logic [PW-1:0]     r_phase;
    logic [DATA_W-1:0] r_shift;
    logic              r_scl;
    logic              r_sda;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    logic [PW-1:0]     w_next_phase;
    logic              w_accept;
    logic              w_run;
    logic              w_tick;

    assign w_accept     = data_valid && r_ready;
    assign w_run        = (r_state == XFER);
    assign w_next_phase = r_phase + PW'(1);

    scl_tick_gen #(
        .HALF(HALF)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .run (w_run),
        .tick(w_tick)
    );

    // Odd phases drop scl and present the next bit; even phases raise scl so the
    // receiver samples. The final odd phase is the stop, where sda rises under a high scl.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_shift <= '0;
            r_scl   <= SCL_IDLE;
            r_sda   <= SDA_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= XFER;
                        r_shift <= data;
                        r_phase <= PW'(PH_START);
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_tick) begin
                        if (r_phase == PW'(PH_LAST)) begin
                            r_state <= IDLE;
                            r_phase <= '0;
                            r_scl   <= SCL_IDLE;
                            r_sda   <= SDA_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_phase <= w_next_phase;
                            if (w_next_phase == PW'(PH_LAST)) begin
                                r_scl <= 1'b1;
                                r_sda <= 1'b1;
                            end else if (w_next_phase[0]) begin
                                r_scl <= 1'b0;
                                if (w_next_phase < PW'(2 * DATA_W + 1)) begin
                                    r_sda   <= r_shift[DATA_W-1];
                                    r_shift <= r_shift << 1;
                                end else begin
                                    r_sda <= 1'b0;
                                end
                            end else begin
                                r_scl <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_ready = r_ready;
    assign scl        = r_scl;
    assign sda        = r_sda;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: three instances (HALF = 2, 1, 3) each run directed
// frames then random traffic, checked against a waveform model and a bus receiver.
module tb_ser_frame_tx;

    localparam int DW    = 4;
    localparam int NDUT  = 3;
    localparam int NRAND = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic int halfOf(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Bus levels for phase p of a frame, written straight from the frame rules.
    function automatic logic expScl(input int p);
        if (p == 2 * DW + 3) return 1'b1;
        if (p % 2 == 1)      return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic expSda(input int p, input logic [DW-1:0] d);
        if (p == 0)          return 1'b0;
        if (p <= 2 * DW)     return d[DW-1-(p-1)/2];
        if (p == 2 * DW + 3) return 1'b1;
        return 1'b0;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int H = halfOf(g);
        localparam int L = (2 * DW + 4) * H;

        logic          rst = 1'b1;
        logic          dataValid = 1'b0;
        logic [DW-1:0] data = '0;
        logic          ready, scl, sda, busy, done;
        bit            finished = 1'b0;

        ser_frame_tx #(
            .DATA_W(DW),
            .HALF  (H)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .data      (data),
            .data_valid(dataValid),
            .data_ready(ready),
            .scl       (scl),
            .sda       (sda),
            .busy      (busy),
            .done      (done)
        );

        int            t = 0;
        bit            inFrame = 1'b0;
        logic [DW-1:0] fd = '0;
        bit            prevAcc = 1'b0;
        logic [DW-1:0] prevData = '0;
        bit            prevRst = 1'b1;
        logic          prevScl = 1'b1;
        logic          prevSda = 1'b1;
        bit            legal;
        bit            rxActive = 1'b0;
        int            rxCnt = 0;
        logic [31:0]   rxBits = '0;
        logic [DW-1:0] rxQ[$];
        logic [DW-1:0] lastRx = '0;
        int            frames = 0;
        int            expFrames = 0;

        // Monitor: frame-position model, protocol rule, and a receiver that decodes the bus.
        always @(negedge clk) begin
            if (prevRst) begin
                inFrame = 1'b0;
            end else if (prevAcc) begin
                inFrame = 1'b1;
                t = 0;
                fd = prevData;
            end else if (inFrame) begin
                t++;
            end

            if (inFrame && t < L) begin
                checkOutput($sformatf("h%0d.scl", H), scl, expScl(t / H));
                checkOutput($sformatf("h%0d.sda", H), sda, expSda(t / H, fd));
                checkOutput($sformatf("h%0d.busy", H), busy, 1);
                checkOutput($sformatf("h%0d.ready", H), ready, 0);
                checkOutput($sformatf("h%0d.done", H), done, 0);
            end else if (inFrame) begin
                checkOutput($sformatf("h%0d.donePulse", H), done, 1);
                checkOutput($sformatf("h%0d.endReady", H), ready, 1);
                checkOutput($sformatf("h%0d.endBusy", H), busy, 0);
                checkOutput($sformatf("h%0d.endBus", H), {scl, sda}, 2'b11);
                checkOutput($sformatf("h%0d.rxHasWord", H), rxQ.size() != 0, 1);
                if (rxQ.size() != 0) checkOutput($sformatf("h%0d.rxWord", H), rxQ.pop_front(), fd);
                inFrame = 1'b0;
                frames++;
            end else begin
                checkOutput($sformatf("h%0d.idleDone", H), done, 0);
                checkOutput($sformatf("h%0d.idleReady", H), ready, 1);
                checkOutput($sformatf("h%0d.idleBusy", H), busy, 0);
                checkOutput($sformatf("h%0d.idleBus", H), {scl, sda}, 2'b11);
            end

            if (prevScl && scl && (sda !== prevSda)) begin
                legal = prevRst ? sda
                      : (inFrame && ((t == 0 && !sda) || (t == (2 * DW + 3) * H && sda)));
                checkOutput($sformatf("h%0d.sdaWhileSclHigh", H), legal, 1);
            end

            if (prevScl && scl && prevSda && !sda) begin
                rxActive = 1'b1;
                rxCnt = 0;
                rxBits = '0;
            end else if (prevScl && scl && !prevSda && sda) begin
                if (rxActive && rxCnt == DW + 1 && rxBits[0] == 1'b0) begin
                    lastRx = rxBits[DW:1];
                    rxQ.push_back(rxBits[DW:1]);
                end
                rxActive = 1'b0;
            end else if (!prevScl && scl && rxActive) begin
                rxBits = {rxBits[30:0], sda};
                rxCnt++;
            end

            prevAcc  = dataValid && ready && !rst;
            prevData = data;
            prevRst  = rst;
            prevScl  = scl;
            prevSda  = sda;
        end

        task automatic waitBusy(input bit want, input string tag);
            int c = 0;
            while (busy !== want && c < 400) begin
                step();
                c++;
            end
            if (busy !== want) checkOutput($sformatf("h%0d.%s", H, tag), busy, want);
        endtask

        task automatic waitDone(output int n);
            n = 0;
            while (done !== 1'b1 && n < 400) begin
                step();
                n++;
            end
            if (done !== 1'b1) checkOutput($sformatf("h%0d.doneTimeout", H), done, 1);
        endtask

        task automatic applyStimulus(input logic [DW-1:0] w);
            dataValid = 1'b1;
            data = w;
            waitBusy(1'b1, "acceptTimeout");
            dataValid = 1'b0;
        endtask

        initial begin : driver
            int  n, gap, hold, c;
            bit  sawDone, sawBusy;
            logic [15:0] onehot;
            repeat (3) step();
            rst = 1'b0;
            step();

            // Basic frame with explicit latency and start-condition checks.
            applyStimulus(4'b1011);
            checkOutput($sformatf("h%0d.startLevels", H), {scl, sda}, 2'b10);
            waitDone(n);
            expFrames++;
            checkOutput($sformatf("h%0d.frameLength", H), n, L);
            checkOutput($sformatf("h%0d.basicWord", H), lastRx, 4'b1011);

            // Back-to-back with data_valid held high.
            dataValid = 1'b1;
            data = 4'hA;
            waitBusy(1'b1, "b2bAccept");
            data = 4'h5;
            waitDone(n);
            expFrames++;
            checkOutput($sformatf("h%0d.b2bFirst", H), lastRx, 4'hA);
            checkOutput($sformatf("h%0d.b2bIdleBus", H), {scl, sda}, 2'b11);
            c = 0;
            while (busy !== 1'b1 && c < 20) begin
                step();
                c++;
            end
            checkOutput($sformatf("h%0d.b2bGap", H), c, 1);
            dataValid = 1'b0;
            waitDone(n);
            expFrames++;
            checkOutput($sformatf("h%0d.b2bSecond", H), lastRx, 4'h5);

            // Handshake: valid held mid-frame with data churning.
            applyStimulus(4'h6);
            dataValid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                data = DW'($urandom);
                step();
                checkOutput($sformatf("h%0d.hsNoAccept", H), ready, 0);
            end
            dataValid = 1'b0;
            waitDone(n);
            expFrames++;
            checkOutput($sformatf("h%0d.hsWord", H), lastRx, 4'h6);

            // Reset mid-frame, with valid offered in the reset cycle.
            applyStimulus(4'h9);
            repeat (DW * H) step();
            rst = 1'b1;
            dataValid = 1'b1;
            data = 4'hF;
            step();
            rst = 1'b0;
            dataValid = 1'b0;
            checkOutput($sformatf("h%0d.rstBus", H), {scl, sda}, 2'b11);
            checkOutput($sformatf("h%0d.rstReady", H), ready, 1);
            checkOutput($sformatf("h%0d.rstBusy", H), busy, 0);
            sawDone = 1'b0;
            sawBusy = 1'b0;
            for (int i = 0; i < 2 * L; i++) begin
                sawDone |= done;
                sawBusy |= busy;
                step();
            end
            checkOutput($sformatf("h%0d.rstNoDone", H), sawDone, 0);
            checkOutput($sformatf("h%0d.rstNoAccept", H), sawBusy, 0);

            // End-to-end into a 16-line decode.
            applyStimulus(4'h3);
            waitDone(n);
            expFrames++;
            onehot = 16'd1 << lastRx;
            checkOutput($sformatf("h%0d.decode", H), onehot, 16'h0008);

            // Random traffic, occasional mid-data resets.
            for (int k = 0; k < NRAND; k++) begin
                gap = $urandom_range(0, 3);
                for (int i = 0; i < gap; i++) begin
                    data = DW'($urandom);
                    step();
                end
                dataValid = 1'b1;
                data = DW'($urandom);
                waitBusy(1'b1, "randAccept");
                hold = $urandom_range(0, 3);
                for (int i = 0; i < hold; i++) begin
                    data = DW'($urandom);
                    step();
                end
                dataValid = 1'b0;
                c = $urandom_range(1, 2 * DW * H - 2);
                if ($urandom_range(0, 4) == 0 && c > hold) begin
                    repeat (c - hold) step();
                    rst = 1'b1;
                    dataValid = 1'($urandom);
                    step();
                    rst = 1'b0;
                    dataValid = 1'b0;
                end else begin
                    expFrames++;
                end
                waitBusy(1'b0, "randFrameEnd");
            end

            repeat (2 * L) step();
            checkOutput($sformatf("h%0d.rxLeftover", H), rxQ.size(), 0);
            checkOutput($sformatf("h%0d.frameCount", H), frames, expFrames);
            finished = 1'b1;
        end
    end

    initial begin
        wait (gDut[0].finished && gDut[1].finished && gDut[2].finished);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected all drivers finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
